// File: rtl/program_counter_if.sv
// Bus between the CPU control path and the program counter: jump target,
// load/increment strobes, and the registered instruction address.
interface program_counter_if #(
   parameter int WIDTH = 16
);
   logic [WIDTH-1:0] in;
   logic             load;
   logic             inc;
   logic [WIDTH-1:0] out;

   modport master (
      output in,
      output load,
      output inc,
      input  out
   );

   modport slave (
      input  in,
      input  load,
      input  inc,
      output out
   );
endinterface

// File: rtl/program_counter.sv
// Hack-style program counter: clear, load jump target, increment or hold on
// each rising edge. The address output comes straight from the register.
module program_counter #(
   parameter int               WIDTH       = 16,
   parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
   input logic                clk,
   input logic                reset,
   program_counter_if.slave   bus
);

   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] out_q;
   logic [WIDTH-1:0] out_d;

   // Load beats increment, so load+inc yields the jump target itself.
   always_comb begin
      out_d = out_q;
      if (bus.load) begin
         out_d = bus.in;
      end else if (bus.inc) begin
         out_d = out_q + ONE;
      end else begin
         out_d = out_q;
      end
   end

   // Counter register; synchronous reset outranks every other control.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_q <= RESET_VALUE;
      end else begin
         out_q <= out_d;
      end
   end

   assign bus.out = out_q;

endmodule

// File: tb/tb_program_counter.sv
// Directed and random checks of program_counter against a one-line reference
// model of the clear/load/increment/hold priority.
module tb_program_counter;

   localparam int WIDTH = 16;

   logic clk;
   logic reset;
   int   tests_run;
   int   tests_failed;
   logic [WIDTH-1:0] exp_q;

   program_counter_if #(.WIDTH(WIDTH)) pc_bus ();

   program_counter #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (pc_bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [WIDTH-1:0] obs,
                           input logic [WIDTH-1:0] exp);
      tests_run = tests_run + 1;
      if (obs !== exp) begin
         tests_failed = tests_failed + 1;
         $display("FAIL %s: out=0x%04h expected 0x%04h", tag, obs, exp);
      end
   endtask

   // Drive one cycle's controls, advance the model, sample out after the edge.
   task automatic step(input string tag, input logic r, input logic ld,
                       input logic ic, input logic [WIDTH-1:0] d,
                       input logic [WIDTH-1:0] hand_exp, input bit use_hand);
      @(negedge clk);
      reset       = r;
      pc_bus.load = ld;
      pc_bus.inc  = ic;
      pc_bus.in   = d;
      @(posedge clk);
      if (r)       exp_q = 16'h0000;
      else if (ld) exp_q = d;
      else if (ic) exp_q = exp_q + 16'h0001;
      #1;
      if (use_hand) check_eq(tag, pc_bus.out, hand_exp);
      else          check_eq(tag, pc_bus.out, exp_q);
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      exp_q        = 16'h0000;
      reset        = 1'b0;
      pc_bus.load  = 1'b0;
      pc_bus.inc   = 1'b0;
      pc_bus.in    = 16'h0000;

      // Initial reset, then reset from a non-zero value and count 1,2,3.
      step("reset_init",  1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
      step("load_5555",   1'b0, 1'b1, 1'b0, 16'h5555, 16'h5555, 1'b1);
      step("reset_clr",   1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
      step("inc_1",       1'b0, 1'b0, 1'b1, 16'h0000, 16'h0001, 1'b1);
      step("inc_2",       1'b0, 1'b0, 1'b1, 16'h0000, 16'h0002, 1'b1);
      step("inc_3",       1'b0, 1'b0, 1'b1, 16'h0000, 16'h0003, 1'b1);

      // Load then hold.
      step("load_1234",   1'b0, 1'b1, 1'b0, 16'h1234, 16'h1234, 1'b1);
      step("hold_1",      1'b0, 1'b0, 1'b0, 16'hAAAA, 16'h1234, 1'b1);
      step("hold_2",      1'b0, 1'b0, 1'b0, 16'h5555, 16'h1234, 1'b1);

      // Load beats increment.
      step("load_inc",    1'b0, 1'b1, 1'b1, 16'h00F0, 16'h00F0, 1'b1);

      // Wrap-around and exact load of extreme values.
      step("load_ffff",   1'b0, 1'b1, 1'b0, 16'hFFFF, 16'hFFFF, 1'b1);
      step("wrap",        1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 1'b1);
      step("inc_after",   1'b0, 1'b0, 1'b1, 16'h0000, 16'h0001, 1'b1);
      step("load_0000",   1'b0, 1'b1, 1'b1, 16'h0000, 16'h0000, 1'b1);

      // Reset beats load and inc.
      step("pre_reset",   1'b0, 1'b1, 1'b0, 16'h7777, 16'h7777, 1'b1);
      step("reset_prio",  1'b1, 1'b1, 1'b1, 16'hBEEF, 16'h0000, 1'b1);
      step("resume",      1'b0, 1'b0, 1'b1, 16'h0000, 16'h0001, 1'b1);

      // Random run against the model, reset pulsed at fixed cycles.
      for (int cyc = 0; cyc < 1000; cyc++) begin
         logic r;
         logic ld;
         logic ic;
         logic [WIDTH-1:0] d;
         r  = (cyc == 10 || cyc == 24 || cyc == 44);
         ld = ($urandom_range(0, 3) == 0);
         ic = ($urandom_range(0, 1) == 1);
         d  = WIDTH'($urandom);
         step("random", r, ld, ic, d, 16'h0000, 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
